// File: rtl/corefifo_fwft_pipe.sv
// First-word-fall-through read stage for CoreFIFO. It supports a parametrised RAM read latency and prefetch depth.
// Optional sticky underrun flag and counter, enabled with the COREFIFO_FWFT_PIPE_ERR_EN macro.
module corefifo_fwft_pipe #(
    parameter int unsigned RWIDTH     = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned PF_DEPTH   = 4,
    parameter int unsigned AE_THRESH  = 1,
    parameter int unsigned LVL_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [RWIDTH-1:0] fifo_dout,
    input  logic              rd_en,
    output logic [RWIDTH-1:0] dout,
    output logic              empty,
    output logic              aempty,
    output logic [LVL_W-1:0]  level,
    output logic              rd_err
);

    localparam int unsigned PW = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int unsigned CW = LVL_W + 2;

    logic [RD_LATENCY-1:0] vld_sr;
    logic [RWIDTH-1:0]     mem [PF_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         rptr_inc_c;
    logic [LVL_W-1:0]      level_nxt_c;
    logic [CW-1:0]         inflight_c;
    logic [CW-1:0]         credit_c;
    logic                  pop_c;
    logic                  cap_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(PF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit rule: words held plus words in flight never exceed the buffer depth.
    always_comb begin
        pop_c       = rd_en && !empty;
        cap_c       = vld_sr[RD_LATENCY-1];
        inflight_c  = CW'($countones(vld_sr));
        credit_c    = CW'(level) + inflight_c - CW'(pop_c);
        fifo_rd_en  = rst && !fifo_empty && (credit_c < CW'(PF_DEPTH));
        rptr_inc_c  = ptr_inc(rptr);
        level_nxt_c = level;
        if (cap_c && !pop_c) begin
            level_nxt_c = level + LVL_W'(1);
        end else if (!cap_c && pop_c) begin
            level_nxt_c = level - LVL_W'(1);
        end
    end

    // In-flight valid pipeline: stage 0 is the read issued this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= fifo_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_c) begin
            mem[wptr] <= fifo_dout;
        end
    end

    // Pointers, level/flags and the head register that presents dout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            empty  <= 1'b1;
            aempty <= 1'b1;
            dout   <= '0;
        end else begin
            if (cap_c) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop_c) begin
                rptr <= rptr_inc_c;
            end
            level  <= level_nxt_c;
            empty  <= (level_nxt_c == '0);
            aempty <= (CW'(level_nxt_c) <= CW'(AE_THRESH));
            // Next head is the captured word when nothing else remains buffered.
            if (cap_c && ((level == '0) || (pop_c && (level == LVL_W'(1))))) begin
                dout <= fifo_dout;
            end else if (pop_c && (level > LVL_W'(1))) begin
                dout <= mem[rptr_inc_c];
            end
        end
    end

`ifdef COREFIFO_FWFT_PIPE_ERR_EN
    logic [7:0] urun_cnt;

    // Sticky underrun flag plus a saturating debug count of underrun attempts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_err   <= 1'b0;
            urun_cnt <= '0;
        end else if (rd_en && empty) begin
            rd_err <= 1'b1;
            if (urun_cnt != 8'hFF) begin
                urun_cnt <= urun_cnt + 8'd1;
            end
        end
    end
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_corefifo_fwft_pipe.sv
// Directed bench for corefifo_fwft_pipe (RD_LATENCY=2, PF_DEPTH=4) with a behavioural FIFO controller model.
// The expected rd_err value follows COREFIFO_FWFT_PIPE_ERR_EN.
module tb_corefifo_fwft_pipe;

    localparam int unsigned RWIDTH     = 8;
    localparam int unsigned RD_LATENCY = 2;
    localparam int unsigned PF_DEPTH   = 4;
    localparam int unsigned AE_THRESH  = 1;
    localparam int unsigned LVL_W      = 5;
`ifdef COREFIFO_FWFT_PIPE_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [RWIDTH-1:0] fifo_dout;
    logic              rd_en;
    logic [RWIDTH-1:0] dout;
    logic              empty;
    logic              aempty;
    logic [LVL_W-1:0]  level;
    logic              rd_err;

    int unsigned checks    = 0;
    int unsigned failures  = 0;
    int unsigned rd_pulses = 0;
    logic [7:0]  q[$];
    logic [7:0]  pipe1 = 8'hEE;
    logic [7:0]  pipe2 = 8'hEE;

    always #5 clk = ~clk;

    corefifo_fwft_pipe #(
        .RWIDTH(RWIDTH), .RD_LATENCY(RD_LATENCY), .PF_DEPTH(PF_DEPTH),
        .AE_THRESH(AE_THRESH), .LVL_W(LVL_W)
    ) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .rd_en(rd_en), .dout(dout), .empty(empty),
        .aempty(aempty), .level(level), .rd_err(rd_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Advance one clock; the controller model returns read data RD_LATENCY cycles after a read.
    task automatic next_cycle();
        logic rd_s;
        #3;
        rd_s = fifo_rd_en;
        if (rd_s) rd_pulses++;
        @(posedge clk);
        #1;
        pipe2 = pipe1;
        if (rd_s && q.size() > 0) pipe1 = q.pop_front();
        else pipe1 = 8'hEE;
        fifo_dout  = pipe2;
        fifo_empty = (q.size() == 0);
        #1;
    endtask

    initial begin
        int exp_w;
        int got;
        int gaps;
        int first;
        rst        = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 8'hEE;
        rd_en      = 1'b0;

        // Reset state
        @(posedge clk);
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_aempty", aempty, 1);
        chk("rst_level", level, 0);
        chk("rst_dout", dout, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            chk("idle_fifo_rd_en", fifo_rd_en, 0);
            chk("idle_empty", empty, 1);
            chk("idle_aempty", aempty, 1);
            chk("idle_level", level, 0);
            chk("idle_dout", dout, 0);
        end

        // Single word latency
        rd_pulses = 0;
        push(8'hA5);
        #1;
        chk("single_rd_en_c0", fifo_rd_en, 1);
        next_cycle();
        chk("single_rd_en_c1", fifo_rd_en, 0);
        chk("single_empty_c1", empty, 1);
        next_cycle();
        chk("single_empty_c2", empty, 1);
        next_cycle();
        chk("single_empty_c3", empty, 0);
        chk("single_dout_c3", dout, 8'hA5);
        chk("single_level_c3", level, 1);
        chk("single_aempty_c3", aempty, 1);
        next_cycle();
        next_cycle();
        rd_en = 1'b1;
        next_cycle();
        rd_en = 1'b0;
        chk("single_empty_c6", empty, 1);
        chk("single_level_c6", level, 0);
        chk("single_pulses", rd_pulses, 1);

        // Continuous stream 0x00..0x3F
        for (int i = 0; i < 64; i++) push(8'(i));
        exp_w = 0; got = 0; gaps = 0; first = -1;
        for (int c = 0; c < 100 && got < 64; c++) begin
            rd_en = !empty;
            if (!empty) begin
                if (first < 0) first = c;
                chk("stream_dout", dout, 32'(exp_w));
                exp_w++;
                got++;
            end else if (first >= 0) begin
                gaps++;
            end
            next_cycle();
        end
        rd_en = 1'b0;
        chk("stream_count", got, 64);
        chk("stream_fill", first, 3);
        chk("stream_gaps", gaps, 0);
        chk("stream_end_empty", empty, 1);
        chk("stream_end_level", level, 0);

        // Prefetch fill with no pops, then drain
        rd_pulses = 0;
        for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
        for (int c = 0; c < 10; c++) next_cycle();
        chk("fill_pulses", rd_pulses, 4);
        chk("fill_rd_en", fifo_rd_en, 0);
        chk("fill_level", level, 4);
        chk("fill_aempty", aempty, 0);
        chk("fill_empty", empty, 0);
        chk("fill_dout", dout, 8'h80);
        exp_w = 8'h80; got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            rd_en = !empty;
            if (!empty) begin
                chk("drain_dout", dout, 32'(exp_w));
                exp_w++;
                got++;
            end
            next_cycle();
        end
        rd_en = 1'b0;
        chk("drain_count", got, 8);

        // Underrun attempt
        chk("urun_pre_empty", empty, 1);
        rd_en = 1'b1;
        next_cycle();
        rd_en = 1'b0;
        chk("urun_rd_err", rd_err, 32'(EXP_ERR));
        chk("urun_level", level, 0);
        chk("urun_empty", empty, 1);
        chk("urun_dout", dout, 8'h87);
        next_cycle();
        next_cycle();
        next_cycle();
        chk("urun_sticky", rd_err, 32'(EXP_ERR));

        // Reset with two reads in flight
        push(8'h11);
        push(8'h22);
        push(8'h33);
        next_cycle();
        next_cycle();
        next_cycle();
        chk("mid_pre_dout", dout, 8'h11);
        chk("mid_pre_level", level, 1);
        rst = 1'b0;
        q.delete();
        fifo_empty = 1'b1;
        #1;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_aempty", aempty, 1);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_rd_err", rd_err, 0);
        chk("mid_rst_fifo_rd_en", fifo_rd_en, 0);
        next_cycle();
        chk("mid_rst_level_c4", level, 0);
        rst = 1'b1;
        next_cycle();
        chk("mid_stale_level_c5", level, 0);
        chk("mid_stale_empty_c5", empty, 1);
        chk("mid_stale_dout_c5", dout, 0);
        next_cycle();
        chk("mid_stale_level_c6", level, 0);
        push(8'h5A);
        got = 0;
        for (int c = 0; c < 10 && empty; c++) begin
            next_cycle();
            got++;
        end
        chk("post_latency", got, 3);
        chk("post_dout", dout, 8'h5A);
        chk("post_level", level, 1);
        rd_en = 1'b1;
        next_cycle();
        rd_en = 1'b0;
        chk("post_empty", empty, 1);
        chk("post_rd_err", rd_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
